multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS core. It sequences a shared datapath (one ALU, one unified instruction/data memory, IR, PC, register file) through fetch, decode, execute, memory and write-back steps for RTYPE, LW, SW, BEQ, BNE, ADDI, ORI, ANDI, SLTI and J. It waits on a ready/request memory handshake, drives every datapath mux and write enable, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Main control FSM of the multi-cycle MIPS core. Sequences the
//             shared datapath through fetch/decode/execute/memory/write-back,
//             handles the ready/request memory handshake and counts retired
//             instructions.
//  Revision : 1.0  initial release
// ============================================================================

// Opcode and ALU encodings; guarded so a shared common.svh definition wins.
`ifndef RTYPE
`define RTYPE 6'b000000
`endif
`ifndef LW
`define LW    6'b100011
`endif
`ifndef SW
`define SW    6'b101011
`endif
`ifndef BEQ
`define BEQ   6'b000100
`endif
`ifndef BNE
`define BNE   6'b000101
`endif
`ifndef ADDI
`define ADDI  6'b001000
`endif
`ifndef ORI
`define ORI   6'b001101
`endif
`ifndef ANDI
`define ANDI  6'b001100
`endif
`ifndef SLTI
`define SLTI  6'b001010
`endif
`ifndef J
`define J     6'b000010
`endif
`ifndef ALU_AND
`define ALU_AND    3'b000
`endif
`ifndef ALU_OR
`define ALU_OR     3'b001
`endif
`ifndef ALU_ADD
`define ALU_ADD    3'b010
`endif
`ifndef ALU_NO_USE
`define ALU_NO_USE 3'b011
`endif
`ifndef ALU_SLT
`define ALU_SLT    3'b111
`endif

module multicycle_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  op,
   input  logic        eq,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        irwrite,
   output logic        pcen,
   output logic [1:0]  pcsrc,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [2:0]  aluop,
   output logic        regdst,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        illegal_op,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      S_BOOT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXEC    = 4'd7,
      S_ALUWB   = 4'd8,
      S_IMMEXEC = 4'd9,
      S_IMMWB   = 4'd10,
      S_BRANCH  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_instret;
   logic        w_retire;

   assign instret = r_instret;

   // State register; reset parks the FSM in BOOT so every output reads 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_BOOT;
      else         r_state <= w_next;
   end

   // Retired-instruction counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)       r_instret <= 32'd0;
      else if (w_retire) r_instret <= r_instret + 32'd1;
   end

   // Next-state and output decode; retire marks the step back into FETCH.
   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = `ALU_ADD;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      illegal_op = 1'b0;
      case (r_state)
         S_BOOT: begin
            aluop  = 3'b000;
            w_next = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            irwrite = mem_ready;
            pcen    = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               `LW, `SW:                   w_next = S_MEMADR;
               `RTYPE:                     w_next = S_EXEC;
               `ADDI, `ORI, `ANDI, `SLTI:  w_next = S_IMMEXEC;
               `BEQ, `BNE:                 w_next = S_BRANCH;
               `J:                         w_next = S_JUMP;
               default: begin
                  illegal_op = 1'b1;
                  w_next     = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            w_next  = (op == `SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               w_next   = S_FETCH;
               w_retire = 1'b1;
            end
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = `ALU_NO_USE;
            w_next  = S_ALUWB;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_IMMEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op)
               `ORI:    aluop = `ALU_OR;
               `ANDI:   aluop = `ALU_AND;
               `SLTI:   aluop = `ALU_SLT;
               default: aluop = `ALU_ADD;
            endcase
            w_next = S_IMMWB;
         end
         S_IMMWB: begin
            regwrite = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_BRANCH: begin
            pcsrc    = 2'b01;
            pcen     = (op == `BNE) ? ~eq : eq;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         S_JUMP: begin
            pcsrc    = 2'b10;
            pcen     = 1'b1;
            w_next   = S_FETCH;
            w_retire = 1'b1;
         end
         default: begin
            aluop  = 3'b000;
            w_next = S_BOOT;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Brief    : Scoreboard bench for multicycle_ctrl. The driver pushes the
//             expected per-cycle output vector and instret; a monitor on the
//             falling edge pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
`ifndef RTYPE
`define RTYPE 6'b000000
`endif
`ifndef LW
`define LW    6'b100011
`endif
`ifndef SW
`define SW    6'b101011
`endif
`ifndef BEQ
`define BEQ   6'b000100
`endif
`ifndef BNE
`define BNE   6'b000101
`endif
`ifndef ADDI
`define ADDI  6'b001000
`endif
`ifndef ORI
`define ORI   6'b001101
`endif
`ifndef ANDI
`define ANDI  6'b001100
`endif
`ifndef SLTI
`define SLTI  6'b001010
`endif
`ifndef J
`define J     6'b000010
`endif
`ifndef ALU_AND
`define ALU_AND    3'b000
`endif
`ifndef ALU_OR
`define ALU_OR     3'b001
`endif
`ifndef ALU_ADD
`define ALU_ADD    3'b010
`endif
`ifndef ALU_NO_USE
`define ALU_NO_USE 3'b011
`endif
`ifndef ALU_SLT
`define ALU_SLT    3'b111
`endif

module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  op;
   logic        eq;
   logic        mem_ready;
   logic        mem_req, mem_we, iord, irwrite, pcen;
   logic [1:0]  pcsrc;
   logic        alusrca;
   logic [1:0]  alusrcb;
   logic [2:0]  aluop;
   logic        regdst, memtoreg, regwrite, illegal_op;
   logic [31:0] instret;

   multicycle_ctrl dut (
      .clk(clk), .resetn(resetn), .op(op), .eq(eq), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite),
      .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .illegal_op(illegal_op), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] vec;
      logic [31:0] ir;
      string       name;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_ir  = 32'd0;

   logic [16:0] w_obs;
   assign w_obs = {mem_req, mem_we, iord, irwrite, pcen, pcsrc, alusrca,
                   alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op};

   function automatic logic [16:0] ov(input logic mreq, input logic mwe,
         input logic io, input logic irw, input logic pce, input logic [1:0] ps,
         input logic asa, input logic [1:0] asb, input logic [2:0] aop,
         input logic rd, input logic m2r, input logic rw, input logic ill);
      return {mreq, mwe, io, irw, pce, ps, asa, asb, aop, rd, m2r, rw, ill};
   endfunction

   // Hand-written expected vectors, one per state/condition.
   logic [16:0] v_zero, v_fetch_w, v_fetch_d, v_decode, v_decode_ill;
   logic [16:0] v_memadr, v_memrd, v_memwb, v_memwr, v_exec, v_aluwb;
   logic [16:0] v_immwb, v_br_t, v_br_n, v_jump;

   // Monitor: pop one expectation per cycle, mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_tests++;
         if (w_obs !== e.vec || instret !== e.ir) begin
            n_fail++;
            $display("FAIL %s: outputs=%b instret=%0d, required outputs=%b instret=%0d",
                     e.name, w_obs, instret, e.vec, e.ir);
         end
      end
   end

   // One cycle: set inputs, queue expectation, advance to just after the edge.
   task automatic step(input logic [16:0] v, input logic mr, input logic e,
                       input string nm);
      exp_t x;
      mem_ready = mr;
      eq        = e;
      x.vec  = v;
      x.ir   = exp_ir;
      x.name = nm;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [5:0] o, input int nwait);
      op = o;
      for (int i = 0; i < nwait; i++) step(v_fetch_w, 1'b0, 1'b0, "fetch_wait");
      step(v_fetch_d, 1'b1, 1'b0, "fetch");
   endtask

   task automatic do_imm(input logic [5:0] o, input logic [2:0] aop, input string nm);
      fetch(o, 0);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(ov(0,0,0,0,0,2'b00,1,2'b10,aop,0,0,0,0), 1'b1, 1'b0, nm);
      step(v_immwb, 1'b1, 1'b0, "immwb");
      exp_ir++;
   endtask

   task automatic do_branch(input logic [5:0] o, input logic e, input logic taken);
      fetch(o, 0);
      step(v_decode, 1'b1, e, "decode");
      step(taken ? v_br_t : v_br_n, 1'b1, e, taken ? "branch_taken" : "branch_not");
      exp_ir++;
   endtask

   initial begin
      v_zero       = 17'd0;
      v_fetch_w    = ov(1,0,0,0,0,2'b00,0,2'b01,`ALU_ADD,0,0,0,0);
      v_fetch_d    = ov(1,0,0,1,1,2'b00,0,2'b01,`ALU_ADD,0,0,0,0);
      v_decode     = ov(0,0,0,0,0,2'b00,0,2'b11,`ALU_ADD,0,0,0,0);
      v_decode_ill = ov(0,0,0,0,0,2'b00,0,2'b11,`ALU_ADD,0,0,0,1);
      v_memadr     = ov(0,0,0,0,0,2'b00,1,2'b10,`ALU_ADD,0,0,0,0);
      v_memrd      = ov(1,0,1,0,0,2'b00,0,2'b00,`ALU_ADD,0,0,0,0);
      v_memwb      = ov(0,0,0,0,0,2'b00,0,2'b00,`ALU_ADD,0,1,1,0);
      v_memwr      = ov(1,1,1,0,0,2'b00,0,2'b00,`ALU_ADD,0,0,0,0);
      v_exec       = ov(0,0,0,0,0,2'b00,1,2'b00,`ALU_NO_USE,0,0,0,0);
      v_aluwb      = ov(0,0,0,0,0,2'b00,0,2'b00,`ALU_ADD,1,0,1,0);
      v_immwb      = ov(0,0,0,0,0,2'b00,0,2'b00,`ALU_ADD,0,0,1,0);
      v_br_t       = ov(0,0,0,0,1,2'b01,0,2'b00,`ALU_ADD,0,0,0,0);
      v_br_n       = ov(0,0,0,0,0,2'b01,0,2'b00,`ALU_ADD,0,0,0,0);
      v_jump       = ov(0,0,0,0,1,2'b10,0,2'b00,`ALU_ADD,0,0,0,0);

      resetn = 1'b0; op = `ADDI; eq = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      step(v_zero, 1'b1, 1'b0, "in_reset");
      step(v_zero, 1'b1, 1'b0, "in_reset");
      resetn = 1'b1;
      step(v_zero, 1'b1, 1'b0, "boot");

      // ADDI with zero-wait memory: 4 cycles
      do_imm(`ADDI, `ALU_ADD, "immexec_addi");

      // LW with 2 fetch waits and 3 read waits: 10 cycles
      fetch(`LW, 2);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(v_memadr, 1'b1, 1'b0, "memadr");
      for (int i = 0; i < 3; i++) step(v_memrd, 1'b0, 1'b0, "memrd_wait");
      step(v_memrd, 1'b1, 1'b0, "memrd");
      step(v_memwb, 1'b1, 1'b0, "memwb");
      exp_ir++;

      // Branches: taken and not taken for both senses
      do_branch(`BEQ, 1'b1, 1'b1);
      do_branch(`BEQ, 1'b0, 1'b0);
      do_branch(`BNE, 1'b0, 1'b1);
      do_branch(`BNE, 1'b1, 1'b0);

      // Illegal opcode: 2 cycles, no retire
      fetch(6'h3F, 0);
      step(v_decode_ill, 1'b1, 1'b0, "decode_illegal");

      // SW then RTYPE
      fetch(`SW, 0);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(v_memadr, 1'b1, 1'b0, "memadr");
      step(v_memwr, 1'b0, 1'b0, "memwr_wait");
      step(v_memwr, 1'b1, 1'b0, "memwr");
      exp_ir++;
      fetch(`RTYPE, 0);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(v_exec, 1'b1, 1'b1, "exec");
      step(v_aluwb, 1'b1, 1'b0, "aluwb");
      exp_ir++;

      // Remaining immediate ops and jump
      do_imm(`ORI,  `ALU_OR,  "immexec_ori");
      do_imm(`ANDI, `ALU_AND, "immexec_andi");
      do_imm(`SLTI, `ALU_SLT, "immexec_slti");
      fetch(`J, 0);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(v_jump, 1'b1, 1'b0, "jump");
      exp_ir++;

      // Reset asserted while LW waits in MEMRD
      fetch(`LW, 0);
      step(v_decode, 1'b1, 1'b0, "decode");
      step(v_memadr, 1'b1, 1'b0, "memadr");
      mem_ready = 1'b0;
      resetn = 1'b0;
      #1;
      n_tests++;
      if (mem_req !== 1'b0 || iord !== 1'b0 || instret !== 32'd0) begin
         n_fail++;
         $display("FAIL async_reset: mem_req=%b iord=%b instret=%0d, required 0 0 0",
                  mem_req, iord, instret);
      end
      exp_ir = 32'd0;
      step(v_zero, 1'b0, 1'b0, "reset_hold");
      step(v_zero, 1'b1, 1'b0, "reset_hold");
      resetn = 1'b1;
      step(v_zero, 1'b1, 1'b0, "boot_after_reset");
      do_imm(`ADDI, `ALU_ADD, "immexec_after_reset");
      fetch(`ADDI, 1);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
